// File: rtl/motor_guard_pkg.sv
// Shared definitions for the dual-motor overcurrent guard: FSM state encoding and default sizing.
package motor_guard_pkg;

    localparam int DEF_PWM_BITS         = 8;
    localparam int DEF_COOL_CYCLES      = 20000000;
    localparam int DEF_RAMP_STEP_CYCLES = 100000;
    localparam int DEF_MAX_RETRY        = 3;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_TRIP,
        ST_COOL,
        ST_RAMP,
        ST_LOCK
    } mg_state_e;

    function automatic logic is_tripped(input mg_state_e s);
        return (s == ST_TRIP) || (s == ST_COOL) || (s == ST_LOCK);
    endfunction

endpackage

// File: rtl/motor_guard_pwm_channel.sv
// One motor gate drive: duty latched per PWM period, capped by a ceiling, compared against the shared counter.
module pwm_channel
    import motor_guard_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [PWM_BITS-1:0] cnt_i,
    input  logic                wrap_i,
    input  logic [PWM_BITS-1:0] duty_i,
    input  logic                en_i,
    input  logic                gate_i,
    input  logic [PWM_BITS-1:0] limit_i,
    output logic [PWM_BITS-1:0] duty_lat_o,
    output logic                pwm_o
);

    logic [PWM_BITS-1:0] duty_q;
    logic [PWM_BITS-1:0] duty_d;
    logic [PWM_BITS-1:0] eff;
    logic                pwm_q;
    logic                pwm_d;

    always_comb begin
        // While the channel is held off there is no pulse to disturb, so it tracks the request freely.
        duty_d = (wrap_i || !gate_i) ? duty_i : duty_q;
        eff    = (duty_q < limit_i) ? duty_q : limit_i;
        pwm_d  = en_i && gate_i && (cnt_i < eff);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign duty_lat_o = duty_q;
    assign pwm_o      = pwm_q;

endmodule

// File: rtl/motor_guard.sv
// Dual-motor overcurrent guard: synchronizes fault and clear inputs, sequences trip, cooldown,
// soft-start and lockout, and gates two PWM channels that share one free-running counter.
module motor_guard
    import motor_guard_pkg::*;
#(
    parameter int PWM_BITS         = DEF_PWM_BITS,
    parameter int COOL_CYCLES      = DEF_COOL_CYCLES,
    parameter int RAMP_STEP_CYCLES = DEF_RAMP_STEP_CYCLES,
    parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [PWM_BITS-1:0] dutyA,
    input  logic [PWM_BITS-1:0] dutyB,
    input  logic                enA,
    input  logic                enB,
    input  logic                oc,
    input  logic                clearBTN,
    output logic                pwmA,
    output logic                pwmB,
    output logic                tripped,
    output logic                lockout,
    output logic [1:0]          retry_cnt
);

    localparam int TIMER_W = $clog2(COOL_CYCLES + 1);
    localparam int STEP_W  = $clog2(RAMP_STEP_CYCLES + 1);

    localparam logic [TIMER_W-1:0] COOL_LOAD = TIMER_W'(COOL_CYCLES - 1);
    localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);
    localparam logic [1:0]         RETRY_MAX = 2'(MAX_RETRY);

    logic                oc_meta_q;
    logic                oc_sync_q;
    logic                clr_meta_q;
    logic                clr_sync_q;
    logic                clr_prev_q;
    logic                clr_rise;

    logic [PWM_BITS-1:0] cnt_q;
    logic [PWM_BITS-1:0] cnt_d;
    logic                wrap;

    mg_state_e           state_q;
    mg_state_e           state_d;
    logic [TIMER_W-1:0]  timer_q;
    logic [TIMER_W-1:0]  timer_d;
    logic [TIMER_W-1:0]  clean_q;
    logic [TIMER_W-1:0]  clean_d;
    logic [PWM_BITS-1:0] ramp_q;
    logic [PWM_BITS-1:0] ramp_d;
    logic [STEP_W-1:0]   step_q;
    logic [STEP_W-1:0]   step_d;
    logic [1:0]          retry_q;
    logic [1:0]          retry_d;
    logic [1:0]          retry_inc;
    logic                tripped_q;
    logic                lockout_q;

    logic [PWM_BITS-1:0] lat_a;
    logic [PWM_BITS-1:0] lat_b;
    logic [PWM_BITS-1:0] duty_max;
    logic [PWM_BITS-1:0] limit;
    logic                gate;

    assign clr_rise  = clr_sync_q && !clr_prev_q;
    assign cnt_d     = cnt_q + 1'b1;
    assign wrap      = &cnt_q;
    assign duty_max  = (lat_a > lat_b) ? lat_a : lat_b;
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 2'd1;

    // The synchronized fault kills the gate one clock before the FSM reaches TRIP.
    assign gate  = ((state_q == ST_RUN) || (state_q == ST_RAMP)) && !oc_sync_q;
    assign limit = (state_q == ST_RAMP) ? ramp_q : '1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            oc_meta_q  <= 1'b0;
            oc_sync_q  <= 1'b0;
            clr_meta_q <= 1'b0;
            clr_sync_q <= 1'b0;
            clr_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            oc_meta_q  <= oc;
            oc_sync_q  <= oc_meta_q;
            clr_meta_q <= clearBTN;
            clr_sync_q <= clr_meta_q;
            clr_prev_q <= clr_sync_q;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        clean_d = '0;
        ramp_d  = ramp_q;
        step_d  = step_q;
        retry_d = retry_q;
        case (state_q)
            ST_RUN: begin
                if (oc_sync_q) begin
                    state_d = ST_TRIP;
                    retry_d = retry_inc;
                end else if (clean_q == COOL_LOAD) begin
                    retry_d = '0;
                end else begin
                    clean_d = clean_q + 1'b1;
                end
            end
            ST_TRIP: begin
                if (retry_q == RETRY_MAX) begin
                    state_d = ST_LOCK;
                end else begin
                    state_d = ST_COOL;
                    timer_d = COOL_LOAD;
                end
            end
            ST_COOL: begin
                if (oc_sync_q) begin
                    timer_d = COOL_LOAD;
                end else if (timer_q == '0) begin
                    state_d = ST_RAMP;
                    ramp_d  = '0;
                    step_d  = '0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_RAMP: begin
                if (oc_sync_q) begin
                    state_d = ST_TRIP;
                    retry_d = retry_inc;
                end else if (ramp_q >= duty_max) begin
                    state_d = ST_RUN;
                end else if (step_q == STEP_LAST) begin
                    step_d = '0;
                    if (ramp_q != '1) begin
                        ramp_d = ramp_q + 1'b1;
                    end
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ST_LOCK: begin
                if (clr_rise && !oc_sync_q) begin
                    state_d = ST_COOL;
                    timer_d = COOL_LOAD;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = ST_COOL;
                timer_d = COOL_LOAD;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change in step with it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_COOL;
            timer_q   <= COOL_LOAD;
            clean_q   <= '0;
            ramp_q    <= '0;
            step_q    <= '0;
            retry_q   <= '0;
            tripped_q <= 1'b1;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            clean_q   <= clean_d;
            ramp_q    <= ramp_d;
            step_q    <= step_d;
            retry_q   <= retry_d;
            tripped_q <= is_tripped(state_d);
            lockout_q <= (state_d == ST_LOCK);
        end
    end

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_chan_a (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .cnt_i      (cnt_q),
        .wrap_i     (wrap),
        .duty_i     (dutyA),
        .en_i       (enA),
        .gate_i     (gate),
        .limit_i    (limit),
        .duty_lat_o (lat_a),
        .pwm_o      (pwmA)
    );

    pwm_channel #(.PWM_BITS(PWM_BITS)) u_chan_b (
        .clk_i      (clock),
        .rst_ni     (reset_n),
        .cnt_i      (cnt_q),
        .wrap_i     (wrap),
        .duty_i     (dutyB),
        .en_i       (enB),
        .gate_i     (gate),
        .limit_i    (limit),
        .duty_lat_o (lat_b),
        .pwm_o      (pwmB)
    );

    assign tripped   = tripped_q;
    assign lockout   = lockout_q;
    assign retry_cnt = retry_q;

endmodule

// File: doc/motor_guard.md
MOTOR_GUARD -- requirements
Module: motor_guard

Interface
REQ-001 Parameter PWM_BITS, default 8, SHALL set duty and PWM counter width.
REQ-002 Parameter COOL_CYCLES, default 20000000, SHALL set cooldown hold-off length and the clean-run retry-clear interval.
REQ-003 Parameter RAMP_STEP_CYCLES, default 100000, SHALL set clocks per soft-start ramp increment.
REQ-004 Parameter MAX_RETRY, default 3, SHALL set trips allowed before lockout.
REQ-005 Port clock, input, 1, SHALL be the single system clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-007 Ports dutyA, dutyB, input, PWM_BITS, SHALL be the requested duty for motor A and motor B.
REQ-008 Ports enA, enB, input, 1, SHALL be the per-motor enables.
REQ-009 Port oc, input, 1, SHALL be the asynchronous overcurrent flag from the comparator.
REQ-010 Port clearBTN, input, 1, SHALL be the asynchronous operator clear button, active-high.
REQ-011 Ports pwmA, pwmB, output, 1, SHALL be the motor gate drives.
REQ-012 Port tripped, output, 1, SHALL be high in TRIP, COOL and LOCK.
REQ-013 Port lockout, output, 1, SHALL be high only in LOCK.
REQ-014 Port retry_cnt, output, 2, SHALL report trips since the last clear.

Function
REQ-015 oc and clearBTN SHALL each pass a 2-flop synchronizer; clearBTN SHALL be edge-detected after synchronization.
REQ-016 A free-running PWM_BITS counter SHALL wrap from 2^PWM_BITS-1 to 0.
REQ-017 pwmX SHALL be registered: enX && (cnt < effX); eff 0 gives constant low, eff 255 gives 255/256 duty.
REQ-018 Requested duty SHALL be latched only on counter wrap; mid-period duty changes SHALL NOT glitch outputs.
REQ-019 FSM states: RUN, TRIP, COOL, RAMP, LOCK.
REQ-020 RUN: effX = latched dutyX; synchronized oc high -> TRIP, retry_cnt increments (saturating at MAX_RETRY).
REQ-021 RUN held continuously for COOL_CYCLES SHALL clear retry_cnt to 0.
REQ-022 TRIP: lasts one clock, pwm low; retry_cnt == MAX_RETRY -> LOCK, else -> COOL with timer loaded to COOL_CYCLES-1.
REQ-023 COOL: pwm low; timer decrements each clock; oc high reloads timer; timer 0 with oc low -> RAMP with ramp_level = 0.
REQ-024 RAMP: effX = min(dutyX, ramp_level); ramp_level increments once per RAMP_STEP_CYCLES, saturating at 2^PWM_BITS-1.
REQ-025 RAMP -> RUN when ramp_level >= max(latched dutyA, latched dutyB); both duties 0 -> RUN on next clock.
REQ-026 oc in RAMP SHALL take priority over the RUN transition -> TRIP.
REQ-027 LOCK: pwm low; clearBTN rising edge with synchronized oc low -> COOL, retry_cnt = 0; clear while oc high SHALL be ignored.
REQ-028 pwmA and pwmB SHALL be low no later than 4 clocks after oc rises.
REQ-029 A clearBTN edge outside LOCK SHALL have no effect.

Reset
REQ-030 reset_n low SHALL asynchronously force: state COOL, timer COOL_CYCLES-1, ramp_level 0, retry_cnt 0, cnt 0, synchronizers 0, pwmA/pwmB 0, tripped 1, lockout 0.
REQ-031 Reset asserted mid-ramp or mid-PWM-period SHALL take effect immediately; exit follows REQ-023 with no partial pulse.

Structure
REQ-032 Package motor_guard_pkg SHALL hold the state enumeration and the default parameter constants.
REQ-033 A sub-module pwm_channel (duty latch, min-compare, registered output; shared counter input) SHALL be instantiated twice.

Verification (COOL_CYCLES=100, RAMP_STEP_CYCLES=4, MAX_RETRY=3, PWM_BITS=8)
REQ-034 Reset release, oc=0, dutyA=128, enA=1 -> pwmA low 100 clocks, ramps, then 128/256 duty in RUN.
REQ-035 oc pulse 10 clocks in RUN -> pwmA low within 4 clocks, retry_cnt=1, tripped=1, RAMP after cooldown.
REQ-036 Three oc pulses without 100 clean RUN clocks -> lockout=1; clearBTN with oc=1 ignored; clearBTN with oc=0 -> COOL, retry_cnt=0.
REQ-037 dutyA 64 -> 200 at counter value 100 -> current period stays 64, next period 200.
REQ-038 oc during RAMP at ramp_level 30 -> TRIP, ramp restarts from 0.
REQ-039 reset_n low mid-RUN at cnt 50 -> pwmA=0 immediately, all outputs at REQ-030 values.
